// File: rtl/stopwatch_pkg.sv
// Shared definitions for the lap stopwatch: FSM state type, the active-low
// seven-segment lookup table and the code shown for a zero digit.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    // Segment order is {g,f,e,d,c,b,a}; a lit segment is driven low.
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry n occupies bits [7n+6:7n]; digit 0 sits in the low bits.
    localparam logic [69:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        SEG_ZERO      // 0
    };

    // Non-BCD codes cannot occur in the counter, but blank them defensively.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] idx;
        idx = 7'(d) * 7'd7;
        if (d > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_TABLE[idx +: 7];
    endfunction

endpackage

// File: rtl/lap_stopwatch_key_edge.sv
// key_edge: two-flop synchroniser for an active-low push button, optional
// debounce filter (compiled in with LAP_STOPWATCH_DEBOUNCE_EN), and a
// one-cycle press pulse on the falling edge of the filtered level.
module key_edge #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_edge: DEBOUNCE_CYCLES must be at least 1");
    end

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic prev_q;

    // Bring the raw button into the clock domain; idle level is released (1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef LAP_STOPWATCH_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            stable_q;
    logic            stable_d;

    // Accept a new level only after it has persisted for the full window.
    always_comb begin
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Debounce counter and filtered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            stable_q <= 1'b1;
        end else begin
            db_cnt_q <= db_cnt_d;
            stable_q <= stable_d;
        end
    end

    assign level = stable_q;
`else
    assign level = sync2_q;
`endif

    // Remember the previous level so a 1->0 transition yields one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign press_o = prev_q & ~level;

endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: BCD stopwatch with IDLE/RUN/PAUSE control, lap memory and
// registered seven-segment outputs. Defining LAP_STOPWATCH_DEBOUNCE_EN adds a
// debounce filter to every key.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICK_CYCLES     = 5000000,
    parameter int DIGITS          = 3,
    parameter int LAPS            = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_clear_n,
    input  logic                key_start_n,
    input  logic                key_lap_n,
    output logic [7*DIGITS-1:0] hex_live,
    output logic [7*DIGITS-1:0] hex_lap,
    output logic [3:0]          lap_idx,
    output logic [4:0]          lap_cnt,
    output logic                running,
    output logic                lap_full,
    output logic                wrapped
);

    localparam int CW      = 4 * DIGITS;
    localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int LAP_AW  = (LAPS > 1) ? $clog2(LAPS) : 1;

    // Key order: 0 clear, 1 start, 2 lap.
    logic [2:0] key_n;
    logic [2:0] press;
    logic       clear_press;
    logic       start_press;
    logic       lap_press;

    assign key_n = {key_lap_n, key_start_n, key_clear_n};

    for (genvar gi = 0; gi < 3; gi++) begin : g_key
        key_edge #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_edge (
            .clk    (clk),
            .rst_n  (rst_n),
            .key_n_i(key_n[gi]),
            .press_o(press[gi])
        );
    end

    assign clear_press = press[0];
    assign start_press = press[1];
    assign lap_press   = press[2];

    sw_state_e            state_q;
    sw_state_e            state_d;
    logic [PRESC_W-1:0]   presc_q;
    logic [PRESC_W-1:0]   presc_d;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic [CW-1:0]        count_inc;
    logic [DIGITS:0]      carry;
    logic [4:0]           lap_cnt_q;
    logic [4:0]           lap_cnt_d;
    logic [3:0]           lap_idx_q;
    logic [3:0]           lap_idx_d;
    logic                 wrapped_q;
    logic                 wrapped_d;
    logic                 lap_store;
    logic                 tick;
    logic [7*DIGITS-1:0]  hex_live_q;
    logic [7*DIGITS-1:0]  hex_live_d;
    logic [7*DIGITS-1:0]  hex_lap_q;
    logic [7*DIGITS-1:0]  hex_lap_d;
    logic [7*DIGITS-1:0]  lap_seg;
    logic [CW-1:0]        lap_rd;
    logic [CW-1:0]        lap_mem [0:LAPS-1];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: clear overrides start.
    always_comb begin
        state_d = state_q;
        if (clear_press) begin
            state_d = ST_IDLE;
        end else if (start_press) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        running = (state_q == ST_RUN);
    end

    assign tick     = running && (presc_q == PRESC_W'(TICK_CYCLES - 1));
    assign lap_full = (lap_cnt_q == 5'(LAPS));

    // BCD increment ripples within one cycle; carry[DIGITS] marks all-9s wrap.
    assign carry[0] = tick;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [3:0] digit;
        assign digit                  = count_q[gi*4 +: 4];
        assign carry[gi+1]            = carry[gi] && (digit == 4'd9);
        assign count_inc[gi*4 +: 4]   = !carry[gi]        ? digit :
                                        (digit == 4'd9)   ? 4'd0  : digit + 4'd1;
        assign hex_live_d[gi*7 +: 7]  = seg_encode(digit);
        assign lap_seg[gi*7 +: 7]     = seg_encode(lap_rd[gi*4 +: 4]);
    end

    assign lap_rd    = lap_mem[lap_idx_q[LAP_AW-1:0]];
    assign hex_lap_d = (lap_cnt_q == 5'd0) ? {DIGITS{SEG_ZERO}} : lap_seg;

    // Datapath next state: clear first, then timing, then the lap action
    // evaluated against the pre-transition state.
    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        lap_cnt_d = lap_cnt_q;
        lap_idx_d = lap_idx_q;
        wrapped_d = wrapped_q;
        lap_store = 1'b0;
        if (clear_press) begin
            presc_d   = '0;
            count_d   = '0;
            lap_cnt_d = '0;
            lap_idx_d = '0;
            wrapped_d = 1'b0;
        end else begin
            if (state_q == ST_RUN) begin
                presc_d = tick ? '0 : presc_q + PRESC_W'(1);
                count_d = count_inc;
                if (carry[DIGITS]) begin
                    wrapped_d = 1'b1;
                end
            end else if ((state_q == ST_IDLE) && start_press) begin
                presc_d = '0;
            end
            if (lap_press) begin
                if (state_q == ST_RUN) begin
                    if (!lap_full) begin
                        lap_store = 1'b1;
                        lap_cnt_d = lap_cnt_q + 5'd1;
                        lap_idx_d = lap_cnt_q[3:0];
                    end
                end else if (lap_cnt_q != 5'd0) begin
                    lap_idx_d = (({1'b0, lap_idx_q} + 5'd1) == lap_cnt_q) ? 4'd0
                                                                         : lap_idx_q + 4'd1;
                end
            end
        end
    end

    // Datapath and display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            count_q    <= '0;
            lap_cnt_q  <= '0;
            lap_idx_q  <= '0;
            wrapped_q  <= 1'b0;
            hex_live_q <= {DIGITS{SEG_ZERO}};
            hex_lap_q  <= {DIGITS{SEG_ZERO}};
        end else begin
            presc_q    <= presc_d;
            count_q    <= count_d;
            lap_cnt_q  <= lap_cnt_d;
            lap_idx_q  <= lap_idx_d;
            wrapped_q  <= wrapped_d;
            hex_live_q <= hex_live_d;
            hex_lap_q  <= hex_lap_d;
        end
    end

    // Lap memory keeps its contents through reset; lap_cnt gates visibility.
    always_ff @(posedge clk) begin
        if (lap_store) begin
            lap_mem[lap_cnt_q[LAP_AW-1:0]] <= count_q;
        end
    end

    assign hex_live = hex_live_q;
    assign hex_lap  = hex_lap_q;
    assign lap_idx  = lap_idx_q;
    assign lap_cnt  = lap_cnt_q;
    assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Scoreboard bench for lap_stopwatch: stimulus pushes expected outputs into a
// queue, a monitor pops and compares them half a cycle after the clock edge.
module tb_lap_stopwatch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    // DUT 1: three digits, two laps, fast tick.
    logic        k_clear_n = 1'b1;
    logic        k_start_n = 1'b1;
    logic        k_lap_n   = 1'b1;
    logic [20:0] hex_live1;
    logic [20:0] hex_lap1;
    logic [3:0]  lap_idx1;
    logic [4:0]  lap_cnt1;
    logic        running1;
    logic        lap_full1;
    logic        wrapped1;

    // DUT 2: two digits for the wrap case.
    logic        k2_clear_n = 1'b1;
    logic        k2_start_n = 1'b1;
    logic        k2_lap_n   = 1'b1;
    logic [13:0] hex_live2;
    logic [13:0] hex_lap2;
    logic [3:0]  lap_idx2;
    logic [4:0]  lap_cnt2;
    logic        running2;
    logic        lap_full2;
    logic        wrapped2;

    lap_stopwatch #(
        .TICK_CYCLES(4), .DIGITS(3), .LAPS(2), .DEBOUNCE_CYCLES(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .key_clear_n(k_clear_n), .key_start_n(k_start_n), .key_lap_n(k_lap_n),
        .hex_live(hex_live1), .hex_lap(hex_lap1),
        .lap_idx(lap_idx1), .lap_cnt(lap_cnt1),
        .running(running1), .lap_full(lap_full1), .wrapped(wrapped1)
    );

    lap_stopwatch #(
        .TICK_CYCLES(4), .DIGITS(2), .LAPS(2), .DEBOUNCE_CYCLES(2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .key_clear_n(k2_clear_n), .key_start_n(k2_start_n), .key_lap_n(k2_lap_n),
        .hex_live(hex_live2), .hex_lap(hex_lap2),
        .lap_idx(lap_idx2), .lap_cnt(lap_cnt2),
        .running(running2), .lap_full(lap_full2), .wrapped(wrapped2)
    );

    typedef struct {
        string       name;
        int          dut;
        logic [20:0] live;
        logic [20:0] lap;
        logic [3:0]  idx;
        logic [4:0]  cnt;
        logic        run;
        logic        full;
        logic        wrap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7f;
        endcase
    endfunction

    function automatic logic [20:0] hex3(input int v);
        return {seg((v / 100) % 10), seg((v / 10) % 10), seg(v % 10)};
    endfunction

    function automatic logic [20:0] hex2(input int v);
        return {7'h00, seg((v / 10) % 10), seg(v % 10)};
    endfunction

    task automatic expect1(input string nm, input int live, input int lapv, input int idx,
                           input int cnt, input logic run, input logic full, input logic wrap);
        exp_t e;
        e.name = nm; e.dut = 1;
        e.live = hex3(live); e.lap = hex3(lapv);
        e.idx = 4'(idx); e.cnt = 5'(cnt);
        e.run = run; e.full = full; e.wrap = wrap;
        sb.push_back(e);
    endtask

    task automatic expect2(input string nm, input int live, input logic run, input logic wrap);
        exp_t e;
        e.name = nm; e.dut = 2;
        e.live = hex2(live); e.lap = hex2(0);
        e.idx = 4'd0; e.cnt = 5'd0;
        e.run = run; e.full = 1'b0; e.wrap = wrap;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.dut == 1) begin
                    chk(e.name, "hex_live", 32'(hex_live1), 32'(e.live));
                    chk(e.name, "hex_lap",  32'(hex_lap1),  32'(e.lap));
                    chk(e.name, "lap_idx",  32'(lap_idx1),  32'(e.idx));
                    chk(e.name, "lap_cnt",  32'(lap_cnt1),  32'(e.cnt));
                    chk(e.name, "running",  32'(running1),  32'(e.run));
                    chk(e.name, "lap_full", 32'(lap_full1), 32'(e.full));
                    chk(e.name, "wrapped",  32'(wrapped1),  32'(e.wrap));
                end else begin
                    chk(e.name, "hex_live", 32'(hex_live2), 32'(e.live));
                    chk(e.name, "hex_lap",  32'(hex_lap2),  32'(e.lap));
                    chk(e.name, "lap_idx",  32'(lap_idx2),  32'(e.idx));
                    chk(e.name, "lap_cnt",  32'(lap_cnt2),  32'(e.cnt));
                    chk(e.name, "running",  32'(running2),  32'(e.run));
                    chk(e.name, "lap_full", 32'(lap_full2), 32'(e.full));
                    chk(e.name, "wrapped",  32'(wrapped2),  32'(e.wrap));
                end
                $display("txn %s dut%0d checked (total=%0d)", e.name, e.dut, total);
            end
        end
    end

    // Wait until the negedge following posedge number e.
    task automatic wait_to(input int e);
        while (edge_no < e) @(negedge clk);
    endtask

    // Press keys so the action lands on posedge number e.
    // Mask bits: 0 clear, 1 start, 2 lap, 3 start of DUT 2.
    task automatic press_on(input int e, input logic [3:0] m);
        while (edge_no < e - 3) @(negedge clk);
        if (m[0]) k_clear_n  = 1'b0;
        if (m[1]) k_start_n  = 1'b0;
        if (m[2]) k_lap_n    = 1'b0;
        if (m[3]) k2_start_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        k_clear_n  = 1'b1;
        k_start_n  = 1'b1;
        k_lap_n    = 1'b1;
        k2_start_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int a0;
        int b0;
        repeat (3) @(negedge clk);
        expect1("reset", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        expect2("reset", 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two-digit wrap: 99 -> 00 sets wrapped and keeps running.
        b0 = edge_no + 3;
        press_on(b0, 4'b1000);
        wait_to(b0 + 397);
        expect2("count_99", 99, 1'b1, 1'b0);
        wait_to(b0 + 401);
        expect2("wrap_00", 0, 1'b1, 1'b1);
        expect1("idle_hold", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        wait_to(b0 + 405);
        expect2("wrap_sticky", 1, 1'b1, 1'b1);

        // Three-digit run with laps.
        a0 = edge_no + 3;
        press_on(a0, 4'b0010);
        press_on(a0 + 16, 4'b0100);
        wait_to(a0 + 17);
        expect1("lap1_003", 4, 3, 0, 1, 1'b1, 1'b0, 1'b0);
        press_on(a0 + 30, 4'b0100);
        wait_to(a0 + 31);
        expect1("lap2_007", 7, 7, 1, 2, 1'b1, 1'b1, 1'b0);
        wait_to(a0 + 41);
        expect1("run40_010", 10, 7, 1, 2, 1'b1, 1'b1, 1'b0);
        press_on(a0 + 50, 4'b0100);
        wait_to(a0 + 51);
        expect1("lap3_ignored", 12, 7, 1, 2, 1'b1, 1'b1, 1'b0);

        // Pause and browse the stored laps.
        press_on(a0 + 54, 4'b0010);
        wait_to(a0 + 56);
        expect1("paused", 13, 7, 1, 2, 1'b0, 1'b1, 1'b0);
        press_on(a0 + 60, 4'b0100);
        wait_to(a0 + 61);
        expect1("view_idx0", 13, 3, 0, 2, 1'b0, 1'b1, 1'b0);
        press_on(a0 + 66, 4'b0100);
        wait_to(a0 + 67);
        expect1("view_idx1", 13, 7, 1, 2, 1'b0, 1'b1, 1'b0);

        // Resume keeps the prescaler phase: next tick two edges later.
        press_on(a0 + 70, 4'b0010);
        wait_to(a0 + 72);
        expect1("resume_pre", 13, 7, 1, 2, 1'b1, 1'b1, 1'b0);
        wait_to(a0 + 73);
        expect1("resume_tick", 14, 7, 1, 2, 1'b1, 1'b1, 1'b0);

        // Clear, start and lap together: clear wins.
        press_on(a0 + 80, 4'b0111);
        wait_to(a0 + 81);
        expect1("clear_all", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        press_on(a0 + 85, 4'b0100);
        wait_to(a0 + 86);
        expect1("idle_lap_empty", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        press_on(a0 + 90, 4'b0010);
        wait_to(a0 + 95);
        expect1("restart_001", 1, 0, 0, 0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between clock edges while running.
        wait_to(a0 + 97);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        expect1("async_reset", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        expect2("async_reset", 0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #3;

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
